// File: rtl/ic_fill_ctrl.sv
// ic_fill_ctrl: instruction-cache miss/fill sequencer.
// Takes line misses from the cache controller and tracks up to four
// outstanding line reads, one per 2-bit transaction id. It issues each read
// to the memory controller and accepts responses in any order. Each returned
// 128-bit line is written into the even/odd data RAMs and into the victim
// way's tag RAM, and the module then reports completion.
module ic_fill_ctrl #(
  parameter int WAYS      = 4,
  parameter int LINE_BITS = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // miss interface from the cache controller
  input  logic                      miss_req,
  input  logic [22:0]               miss_addr,
  input  logic [$clog2(WAYS)-1:0]   miss_way,
  output logic                      miss_ready,
  output logic                      miss_dup,
  // request interface to the memory controller
  output logic [22:0]               ic_mem_addr,
  output logic [1:0]                ic_mem_xid,
  output logic                      ic_mem_re,
  input  logic                      mem_ic_ready,
  // response interface from the memory controller
  input  logic                      mem_ic_valid,
  input  logic [1:0]                mem_ic_xid,
  input  logic [127:0]              mem_ic_data,
  // data RAM write port
  output logic                      we_data,
  output logic [$clog2(WAYS)-1:0]   wr_way,
  output logic [LINE_BITS-1:0]      wr_line,
  output logic [63:0]               wr_data_even,
  output logic [63:0]               wr_data_odd,
  // tag RAM write port (one RAM per way)
  output logic [WAYS-1:0]           we_tag,
  output logic [LINE_BITS-1:0]      waddr_tag,
  output logic [23-LINE_BITS:0]     wdata_tag,
  // completion and error reporting
  output logic                      fill_done,
  output logic [22:0]               fill_addr,
  output logic                      err_xid
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = 23 - LINE_BITS;
  localparam int N_XID = 4;

  // Tracker table, indexed by transaction id.
  logic [N_XID-1:0] r_valid;
  logic [22:0]      r_addr [N_XID];
  logic [WAY_W-1:0] r_way  [N_XID];

  // Request stage: holds one read until the memory controller takes it.
  logic             r_req_vld;
  logic [22:0]      r_req_addr;
  logic [1:0]       r_req_xid;

  // Fill stage: holds one returned line for its single write cycle.
  logic             r_fill_vld;
  logic [1:0]       r_fill_xid;
  logic [22:0]      r_fill_addr;
  logic [WAY_W-1:0] r_fill_way;
  logic [127:0]     r_fill_data;

  logic             r_err;
  logic             r_ready_en;

  logic             w_free_any;
  logic [1:0]       w_free_xid;
  logic             w_match;
  logic             w_miss_ready;
  logic             w_accept;
  logic             w_alloc;
  logic             w_rsp_hit;
  logic             w_rsp_err;

  // Find the lowest free transaction id.
  // NOTE: every combinationally assigned signal gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_free_any = 1'b0;
    w_free_xid = '0;
    for (int i = N_XID - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_xid = 2'(i);
      end
    end
  end

  // Check whether the incoming miss address is already being fetched.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < N_XID; i++) begin
      if (r_valid[i] && (r_addr[i] == miss_addr)) begin
        w_match = 1'b1;
      end
    end
  end

  // A new miss is accepted only when an id is free and both stages are idle.
  // An idle fill stage guarantees that the victim invalidate never competes
  // with a refill for the tag write port.
  assign w_miss_ready = r_ready_en & w_free_any & ~r_req_vld & ~r_fill_vld;
  assign w_accept     = miss_req & w_miss_ready;
  assign w_alloc      = w_accept & ~w_match;

  // A response is accepted only for an allocated id. The id being retired
  // this cycle counts as already free, so a repeated response for it is
  // treated as stray.
  assign w_rsp_hit = mem_ic_valid & r_valid[mem_ic_xid] &
                     ~(r_fill_vld && (r_fill_xid == mem_ic_xid));
  assign w_rsp_err = mem_ic_valid & ~w_rsp_hit;

  // Maintain the tracker valid bits: set on allocation, clear on fill write.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[w_free_xid] <= 1'b1;
      end
      if (r_fill_vld) begin
        r_valid[r_fill_xid] <= 1'b0;
      end
    end
  end

  // Capture the address and victim way of a newly allocated miss.
  // NOTE: this payload storage is deliberately left unreset. The valid bit
  // guards it, and skipping reset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[w_free_xid] <= miss_addr;
      r_way[w_free_xid]  <= miss_way;
    end
  end

  // Request stage: load on allocation, empty after the memory handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_vld  <= 1'b0;
      r_req_addr <= '0;
      r_req_xid  <= '0;
    end else if (w_alloc) begin
      r_req_vld  <= 1'b1;
      r_req_addr <= miss_addr;
      r_req_xid  <= w_free_xid;
    end else if (r_req_vld && mem_ic_ready) begin
      r_req_vld  <= 1'b0;
    end
  end

  // Fill stage: register each valid response for a one-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_vld  <= 1'b0;
      r_fill_xid  <= '0;
      r_fill_addr <= '0;
      r_fill_way  <= '0;
      r_fill_data <= '0;
    end else begin
      r_fill_vld <= w_rsp_hit;
      if (w_rsp_hit) begin
        r_fill_xid  <= mem_ic_xid;
        r_fill_addr <= r_addr[mem_ic_xid];
        r_fill_way  <= r_way[mem_ic_xid];
        r_fill_data <= mem_ic_data;
      end
    end
  end

  // Set the sticky error flag on any response to an id that is not allocated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_rsp_err) begin
      r_err <= 1'b1;
    end
  end

  // Hold miss_ready low during reset, then enable it one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // Split the line into even halfwords (0,2,4,6) and odd halfwords (1,3,5,7).
  always_comb begin
    wr_data_even = '0;
    wr_data_odd  = '0;
    for (int k = 0; k < 4; k++) begin
      wr_data_even[16*k +: 16] = r_fill_data[32*k      +: 16];
      wr_data_odd[16*k +: 16]  = r_fill_data[32*k + 16 +: 16];
    end
  end

  // Drive the tag write port: a refill takes priority, otherwise a new
  // allocation invalidates the victim line.
  always_comb begin
    we_tag    = '0;
    waddr_tag = '0;
    wdata_tag = '0;
    if (r_fill_vld) begin
      we_tag[r_fill_way] = 1'b1;
      waddr_tag          = r_fill_addr[LINE_BITS-1:0];
      wdata_tag          = {1'b1, r_fill_addr[22:LINE_BITS]};
    end else if (w_alloc) begin
      we_tag[miss_way] = 1'b1;
      waddr_tag        = miss_addr[LINE_BITS-1:0];
      wdata_tag        = {1'b0, {TAG_W{1'b0}}};
    end
  end

  assign miss_ready  = w_miss_ready;
  assign miss_dup    = w_accept & w_match;

  assign ic_mem_re   = r_req_vld;
  assign ic_mem_addr = r_req_addr;
  assign ic_mem_xid  = r_req_xid;

  assign we_data     = r_fill_vld;
  assign wr_way      = r_fill_way;
  assign wr_line     = r_fill_addr[LINE_BITS-1:0];

  assign fill_done   = r_fill_vld;
  assign fill_addr   = r_fill_vld ? r_fill_addr : '0;
  assign err_xid     = r_err;

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Self-checking bench for ic_fill_ctrl. It keeps a small tracker model and
// two scoreboard queues: expected memory requests and expected fill writes.
// A negedge monitor pops and compares entries whenever the DUT handshakes a
// request or writes a line.
module tb_ic_fill_ctrl;

  localparam int WAYS      = 4;
  localparam int LINE_BITS = 6;
  localparam int TAG_W     = 23 - LINE_BITS;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   miss_req;
  logic [22:0]            miss_addr;
  logic [1:0]             miss_way;
  logic                   miss_ready;
  logic                   miss_dup;
  logic [22:0]            ic_mem_addr;
  logic [1:0]             ic_mem_xid;
  logic                   ic_mem_re;
  logic                   mem_ic_ready;
  logic                   mem_ic_valid;
  logic [1:0]             mem_ic_xid;
  logic [127:0]           mem_ic_data;
  logic                   we_data;
  logic [1:0]             wr_way;
  logic [LINE_BITS-1:0]   wr_line;
  logic [63:0]            wr_data_even;
  logic [63:0]            wr_data_odd;
  logic [WAYS-1:0]        we_tag;
  logic [LINE_BITS-1:0]   waddr_tag;
  logic [TAG_W:0]         wdata_tag;
  logic                   fill_done;
  logic [22:0]            fill_addr;
  logic                   err_xid;

  always #5 clk = ~clk;

  ic_fill_ctrl #(.WAYS(WAYS), .LINE_BITS(LINE_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_way(miss_way),
    .miss_ready(miss_ready), .miss_dup(miss_dup),
    .ic_mem_addr(ic_mem_addr), .ic_mem_xid(ic_mem_xid), .ic_mem_re(ic_mem_re),
    .mem_ic_ready(mem_ic_ready),
    .mem_ic_valid(mem_ic_valid), .mem_ic_xid(mem_ic_xid), .mem_ic_data(mem_ic_data),
    .we_data(we_data), .wr_way(wr_way), .wr_line(wr_line),
    .wr_data_even(wr_data_even), .wr_data_odd(wr_data_odd),
    .we_tag(we_tag), .waddr_tag(waddr_tag), .wdata_tag(wdata_tag),
    .fill_done(fill_done), .fill_addr(fill_addr), .err_xid(err_xid)
  );

  typedef struct { logic [22:0] addr; logic [1:0] way; } miss_vec_t;
  typedef struct { logic [1:0] xid; logic [127:0] data; logic [63:0] even; logic [63:0] odd; } rsp_vec_t;
  typedef struct { logic [22:0] addr; logic [1:0] xid; } req_exp_t;
  typedef struct { logic [22:0] addr; logic [1:0] way; logic [63:0] even; logic [63:0] odd; } fill_exp_t;

  int n_checks = 0;
  int n_errors = 0;

  req_exp_t  req_q[$];
  fill_exp_t fill_q[$];

  bit          mdl_valid [4];
  logic [22:0] mdl_addr  [4];
  logic [1:0]  mdl_way   [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!mdl_valid[i]) return i;
    return -1;
  endfunction

  // Scoreboard monitor: compare request handshakes and line writes.
  always @(negedge clk) begin
    req_exp_t  re;
    fill_exp_t fe;
    if (rst_n) begin
      if (ic_mem_re && mem_ic_ready) begin
        if (req_q.size() == 0) check("req_unexpected", 1, 0);
        else begin
          re = req_q.pop_front();
          check("req_addr", ic_mem_addr, re.addr);
          check("req_xid", ic_mem_xid, re.xid);
        end
      end
      if (we_data) begin
        if (fill_q.size() == 0) check("fill_unexpected", 1, 0);
        else begin
          fe = fill_q.pop_front();
          check("fill_done", fill_done, 1);
          check("fill_addr", fill_addr, fe.addr);
          check("wr_way", wr_way, fe.way);
          check("wr_line", wr_line, fe.addr[LINE_BITS-1:0]);
          check("wr_even", wr_data_even, fe.even);
          check("wr_odd", wr_data_odd, fe.odd);
          check("fill_we_tag", we_tag, 4'b0001 << fe.way);
          check("fill_waddr_tag", waddr_tag, fe.addr[LINE_BITS-1:0]);
          check("fill_wdata_tag", wdata_tag, {1'b1, fe.addr[22:LINE_BITS]});
        end
      end
    end
  end

  // Present a miss (entered and left at posedge+1); wait for acceptance and
  // check the same-cycle dup flag and victim invalidate.
  task automatic do_miss(input logic [22:0] a, input logic [1:0] w, input bit exp_dup);
    int       xid;
    int       k;
    req_exp_t re;
    miss_req  = 1'b1;
    miss_addr = a;
    miss_way  = w;
    k = 0;
    @(negedge clk);
    while (!miss_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("miss_ready_wait", miss_ready, 1);
    check("miss_dup", miss_dup, exp_dup);
    if (exp_dup) begin
      check("dup_we_tag", we_tag, 0);
    end else begin
      xid = lowest_free();
      check("inval_we_tag", we_tag, 4'b0001 << w);
      check("inval_waddr", waddr_tag, a[LINE_BITS-1:0]);
      check("inval_wdata", wdata_tag, 0);
      if (xid >= 0) begin
        mdl_valid[xid] = 1'b1;
        mdl_addr[xid]  = a;
        mdl_way[xid]   = w;
        re.addr = a;
        re.xid  = 2'(xid);
        req_q.push_back(re);
      end
    end
    @(posedge clk); #1;
    miss_req  = 1'b0;
    miss_addr = '0;
    miss_way  = '0;
  endtask

  // Drive one response cycle; the caller drops mem_ic_valid afterwards.
  task automatic send_rsp(input logic [1:0] x, input logic [127:0] d,
                          input logic [63:0] ev, input logic [63:0] od);
    fill_exp_t fe;
    mem_ic_valid = 1'b1;
    mem_ic_xid   = x;
    mem_ic_data  = d;
    if (mdl_valid[x]) begin
      fe.addr = mdl_addr[x];
      fe.way  = mdl_way[x];
      fe.even = ev;
      fe.odd  = od;
      fill_q.push_back(fe);
      mdl_valid[x] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    miss_vec_t mv [5];
    rsp_vec_t  rv [4];

    mv[0] = '{23'h0A1B2C, 2'd0};
    mv[1] = '{23'h000040, 2'd1};
    mv[2] = '{23'h7FFFFF, 2'd3};
    mv[3] = '{23'h012345, 2'd2};
    mv[4] = '{23'h055555, 2'd1};
    // Responses in order 3,1,0,2; halfword k of each line is base+k.
    rv[0] = '{2'd3, 128'h3007_3006_3005_3004_3003_3002_3001_3000,
              64'h3006_3004_3002_3000, 64'h3007_3005_3003_3001};
    rv[1] = '{2'd1, 128'h1007_1006_1005_1004_1003_1002_1001_1000,
              64'h1006_1004_1002_1000, 64'h1007_1005_1003_1001};
    rv[2] = '{2'd0, 128'hA007_A006_A005_A004_A003_A002_A001_A000,
              64'hA006_A004_A002_A000, 64'hA007_A005_A003_A001};
    rv[3] = '{2'd2, 128'h2007_2006_2005_2004_2003_2002_2001_2000,
              64'h2006_2004_2002_2000, 64'h2007_2005_2003_2001};

    miss_req = 1'b0; miss_addr = '0; miss_way = '0;
    mem_ic_ready = 1'b1; mem_ic_valid = 1'b0; mem_ic_xid = '0; mem_ic_data = '0;
    for (int i = 0; i < 4; i++) mdl_valid[i] = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_miss_ready", miss_ready, 0);
    check("rst_mem_re", ic_mem_re, 0);
    check("rst_we_data", we_data, 0);
    check("rst_we_tag", we_tag, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_err_xid", err_xid, 0);
    check("rst_wr_even", wr_data_even, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    @(negedge clk);
    check("post_rst_ready", miss_ready, 1);
    idle(1);

    // 1: byte address 0x123 -> line address 0x12, line 0x12, tag 0, way 2.
    do_miss(23'h000012, 2'd2, 1'b0);
    idle(2);
    send_rsp(2'd0, 128'h5007_5006_5005_5004_5003_5002_5001_5000,
             64'h5006_5004_5002_5000, 64'h5007_5005_5003_5001);
    mem_ic_valid = 1'b0;
    idle(2);

    // 2: fill all four ids, then free xid2 and reuse it.
    for (int i = 0; i < 4; i++) do_miss(mv[i].addr, mv[i].way, 1'b0);
    idle(2);
    @(negedge clk);
    check("full_miss_ready", miss_ready, 0);
    @(posedge clk); #1;
    send_rsp(2'd2, 128'hC007_C006_C005_C004_C003_C002_C001_C000,
             64'hC006_C004_C002_C000, 64'hC007_C005_C003_C001);
    mem_ic_valid = 1'b0;
    do_miss(mv[4].addr, mv[4].way, 1'b0);
    idle(2);

    // 3: out-of-order responses, back to back.
    for (int i = 0; i < 4; i++) send_rsp(rv[i].xid, rv[i].data, rv[i].even, rv[i].odd);
    mem_ic_valid = 1'b0;
    idle(2);
    check("fills_drained", fill_q.size(), 0);

    // 4: memory stalls the request for five cycles.
    mem_ic_ready = 1'b0;
    do_miss(23'h2AAAAA, 2'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_re", ic_mem_re, 1);
      check("stall_addr", ic_mem_addr, 23'h2AAAAA);
      check("stall_xid", ic_mem_xid, 0);
      check("stall_miss_ready", miss_ready, 0);
    end
    @(posedge clk); #1;
    mem_ic_ready = 1'b1;
    idle(2);

    // 5: duplicate miss to the in-flight line.
    do_miss(23'h2AAAAA, 2'd1, 1'b1);
    @(negedge clk);
    check("dup_no_req", ic_mem_re, 0);
    @(negedge clk);
    check("dup_no_req2", ic_mem_re, 0);
    @(posedge clk); #1;

    // 6: halfword split of k*0x1111, fill goes to original way 3.
    send_rsp(2'd0, 128'h7777_6666_5555_4444_3333_2222_1111_0000,
             64'h6666_4444_2222_0000, 64'h7777_5555_3333_1111);
    mem_ic_valid = 1'b0;
    idle(2);
    check("err_before_stray", err_xid, 0);
    send_rsp(2'd1, 128'hDEAD, 64'h0, 64'h0);
    mem_ic_valid = 1'b0;
    @(negedge clk);
    check("stray_err_xid", err_xid, 1);
    check("stray_no_write", we_data, 0);
    idle(2);
    @(negedge clk);
    check("err_sticky", err_xid, 1);
    @(posedge clk); #1;

    // Reset with a line in flight; a stale response afterwards is dropped.
    do_miss(23'h001234, 2'd0, 1'b0);
    idle(2);
    rst_n = 1'b0;
    #2;
    check("midrst_err_clr", err_xid, 0);
    check("midrst_ready", miss_ready, 0);
    check("midrst_re", ic_mem_re, 0);
    for (int i = 0; i < 4; i++) mdl_valid[i] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_rsp(2'd0, 128'hBEEF, 64'h0, 64'h0);
    mem_ic_valid = 1'b0;
    @(negedge clk);
    check("stale_err_xid", err_xid, 1);
    check("stale_no_write", we_data, 0);
    check("stale_miss_ready", miss_ready, 1);
    idle(2);

    check("req_q_empty", req_q.size(), 0);
    check("fill_q_empty", fill_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
